// File: rtl/ula_arbiter_if.sv
// Request/response handshake bundle between the bus-side masters and the ULA arbiter.
// Two request channels share one registered response path.
interface ula_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int SELW  = 2
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [SELW-1:0]  req0_sel;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [SELW-1:0]  req1_sel;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [WIDTH-1:0] resp_resul;
  logic             resp_flag;

  modport master (
    output req_valid, req0_a, req0_b, req0_sel, req1_a, req1_b, req1_sel, resp_ready,
    input  req_ready, resp_valid, resp_resul, resp_flag
  );

  modport slave (
    input  req_valid, req0_a, req0_b, req0_sel, req1_a, req1_b, req1_sel, resp_ready,
    output req_ready, resp_valid, resp_resul, resp_flag
  );
endinterface

// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one combinational ULA between two requesters.
// IDLE accepts one request, EXEC drives the ULA for a cycle, RESP holds the result until consumed.
module ula_arbiter #(
  parameter int WIDTH = 4,
  parameter int SELW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  ula_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] ula_a,
  output logic [WIDTH-1:0] ula_b,
  output logic [SELW-1:0]  ula_sel,
  input  logic [WIDTH-1:0] ula_resul,
  input  logic             ula_flag,
  output logic             busy,
  output logic             grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             prio_r;
  logic             grant_r;
  logic             busy_r;
  logic             winner_s;
  logic             accept_s;
  logic             done_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [SELW-1:0]  sel_r;
  logic [1:0]       resp_valid_r;
  logic [WIDTH-1:0] resul_r;
  logic             flag_r;

  // Arbitration, handshake decode and next-state selection
  always_comb begin
    state_next_s  = state_r;
    winner_s      = prio_r;
    accept_s      = 1'b0;
    done_s        = 1'b0;
    bus.req_ready = 2'b00;
    case (state_r)
      IDLE: begin
        if (bus.req_valid[prio_r]) begin
          winner_s = prio_r;
          accept_s = 1'b1;
        end else if (bus.req_valid[~prio_r]) begin
          winner_s = ~prio_r;
          accept_s = 1'b1;
        end else begin
          winner_s = prio_r;
          accept_s = 1'b0;
        end
        // Ready is withheld during reset so nothing looks accepted that will be dropped.
        if (accept_s && !rst) begin
          bus.req_ready = 2'b01 << winner_s;
        end else begin
          bus.req_ready = 2'b00;
        end
        if (accept_s) begin
          state_next_s = EXEC;
        end else begin
          state_next_s = IDLE;
        end
      end
      EXEC: begin
        state_next_s = RESP;
      end
      RESP: begin
        if (bus.resp_ready[grant_r]) begin
          done_s       = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, priority and busy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      prio_r  <= 1'b0;
      grant_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        grant_r <= winner_s;
        busy_r  <= 1'b1;
      end
      if (done_s) begin
        busy_r <= 1'b0;
        prio_r <= ~grant_r;
      end
    end
  end

  // Operand latch in the accept cycle; these regs feed the ULA directly
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
      sel_r <= {SELW{1'b0}};
    end else if (accept_s) begin
      a_r   <= winner_s ? bus.req1_a   : bus.req0_a;
      b_r   <= winner_s ? bus.req1_b   : bus.req0_b;
      sel_r <= winner_s ? bus.req1_sel : bus.req0_sel;
    end
  end

  // Result capture at the end of EXEC and response valid handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      resul_r      <= {WIDTH{1'b0}};
      flag_r       <= 1'b0;
      resp_valid_r <= 2'b00;
    end else begin
      if (state_r == EXEC) begin
        resul_r      <= ula_resul;
        flag_r       <= ula_flag;
        resp_valid_r <= 2'b01 << grant_r;
      end else if (done_s) begin
        resp_valid_r <= 2'b00;
      end
    end
  end

  assign ula_a          = a_r;
  assign ula_b          = b_r;
  assign ula_sel        = sel_r;
  assign busy           = busy_r;
  assign grant_id       = grant_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_resul = resul_r;
  assign bus.resp_flag  = flag_r;

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed bench for ula_arbiter: table of single operations plus hand-written sequences for
// reset, backpressure, operand change after accept and reset during an operation.
module tb_ula_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] ula_a;
  logic [3:0] ula_b;
  logic [1:0] ula_sel;
  logic [3:0] ula_resul;
  logic       ula_flag;
  logic       busy;
  logic       grant_id;
  logic [4:0] ula_t;

  int n_pass;
  int n_total;

  ula_arbiter_if #(.WIDTH(4), .SELW(2)) bus ();

  ula_arbiter #(.WIDTH(4), .SELW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ula_a     (ula_a),
    .ula_b     (ula_b),
    .ula_sel   (ula_sel),
    .ula_resul (ula_resul),
    .ula_flag  (ula_flag),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  // Standalone ULA: add/carry, sub/borrow, and/zero, or/zero
  always_comb begin
    ula_t = 5'd0;
    case (ula_sel)
      2'b00:   ula_t = {1'b0, ula_a} + {1'b0, ula_b};
      2'b01:   ula_t = {1'b0, ula_a} - {1'b0, ula_b};
      2'b10:   ula_t = {((ula_a & ula_b) == 4'd0), (ula_a & ula_b)};
      default: ula_t = {((ula_a | ula_b) == 4'd0), (ula_a | ula_b)};
    endcase
  end
  assign ula_resul = ula_t[3:0];
  assign ula_flag  = ula_t[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] valid;
    logic [3:0] a0;
    logic [3:0] b0;
    logic [1:0] s0;
    logic [3:0] a1;
    logic [3:0] b1;
    logic [1:0] s1;
    logic       grant;
    logic [3:0] resul;
    logic       flag;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic set_ops(input vec_t v);
    bus.req0_a   = v.a0;
    bus.req0_b   = v.b0;
    bus.req0_sel = v.s0;
    bus.req1_a   = v.a1;
    bus.req1_b   = v.b1;
    bus.req1_sel = v.s1;
  endtask

  // One full operation: accept, EXEC, RESP, consume
  task automatic run_op(input vec_t v, input int idx);
    logic [1:0] oh;
    oh = 2'b01 << v.grant;
    @(negedge clk);
    set_ops(v);
    bus.req_valid = v.valid;
    #1;
    chk($sformatf("v%0d accept", idx), {busy, bus.req_ready}, {1'b0, oh});
    @(negedge clk);
    #1;
    chk($sformatf("v%0d exec", idx), {busy, bus.req_ready, bus.resp_valid, ula_a, ula_b, ula_sel},
        {1'b1, 2'b00, 2'b00, (v.grant ? v.a1 : v.a0), (v.grant ? v.b1 : v.b0), (v.grant ? v.s1 : v.s0)});
    bus.req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk($sformatf("v%0d resp", idx), {bus.resp_valid, bus.resp_resul, bus.resp_flag, grant_id},
        {oh, v.resul, v.flag, v.grant});
    bus.resp_ready = oh;
    @(negedge clk);
    bus.resp_ready = 2'b00;
    #1;
    chk($sformatf("v%0d done", idx), {bus.resp_valid, busy}, {2'b00, 1'b0});
  endtask

  initial begin
    vec_t w;
    n_pass  = 0;
    n_total = 0;
    //          valid  a0     b0     s0     a1     b1     s1     gnt   resul  flag
    vecs[0] = '{2'b01, 4'h7, 4'h6, 2'b01, 4'h0, 4'h0, 2'b00, 1'b0, 4'h1, 1'b0};
    vecs[1] = '{2'b11, 4'hF, 4'h1, 2'b00, 4'h3, 4'h2, 2'b01, 1'b1, 4'h1, 1'b0};
    vecs[2] = '{2'b11, 4'hF, 4'h1, 2'b00, 4'h3, 4'h2, 2'b01, 1'b0, 4'h0, 1'b1};
    vecs[3] = '{2'b01, 4'hC, 4'hA, 2'b10, 4'h0, 4'h0, 2'b00, 1'b0, 4'h8, 1'b0};
    vecs[4] = '{2'b10, 4'h0, 4'h0, 2'b00, 4'h5, 4'hA, 2'b11, 1'b1, 4'hF, 1'b0};
    vecs[5] = '{2'b10, 4'h0, 4'h0, 2'b00, 4'h6, 4'h9, 2'b10, 1'b1, 4'h0, 1'b1};
    vecs[6] = '{2'b01, 4'h9, 4'h8, 2'b00, 4'h0, 4'h0, 2'b00, 1'b0, 4'h1, 1'b1};
    vecs[7] = '{2'b10, 4'h0, 4'h0, 2'b00, 4'h2, 4'h5, 2'b01, 1'b1, 4'hD, 1'b1};

    rst            = 1'b1;
    bus.req_valid  = 2'b00;
    bus.resp_ready = 2'b00;
    set_ops(vecs[0]);

    // Reset held two cycles, then idle with no requests
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset outputs", {bus.req_ready, bus.resp_valid, bus.resp_resul, bus.resp_flag,
        ula_a, ula_b, ula_sel, busy, grant_id}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("idle after reset", {bus.req_ready, bus.resp_valid, busy}, 32'd0);

    // Single op, contention with alternation, and single-requester back-to-back
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], i);
    end

    // Backpressure: ch0 wins, ch1 keeps requesting while the response is stalled
    w = '{2'b11, 4'hA, 4'h3, 2'b00, 4'h4, 4'h1, 2'b01, 1'b0, 4'hD, 1'b0};
    @(negedge clk);
    set_ops(w);
    bus.req_valid = 2'b11;
    #1;
    chk("bp accept", bus.req_ready, 2'b01);
    @(negedge clk);
    #1;
    chk("bp exec", {busy, bus.req_ready}, {1'b1, 2'b00});
    bus.req_valid = 2'b10;
    @(negedge clk);
    bus.resp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp stall %0d", i), {bus.resp_valid, bus.resp_resul, bus.resp_flag, busy, bus.req_ready},
          {2'b01, 4'hD, 1'b0, 1'b1, 2'b00});
      @(negedge clk);
    end
    bus.resp_ready = 2'b01;
    #1;
    chk("bp release", {bus.resp_valid, bus.req_ready}, {2'b01, 2'b00});
    @(negedge clk);
    bus.resp_ready = 2'b00;
    #1;
    chk("bp ch1 accept", {bus.resp_valid, bus.req_ready}, {2'b00, 2'b10});
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk("bp ch1 resp", {bus.resp_valid, bus.resp_resul, bus.resp_flag, grant_id}, {2'b10, 4'h3, 1'b0, 1'b1});
    bus.resp_ready = 2'b10;
    @(negedge clk);
    bus.resp_ready = 2'b00;

    // Operand changed by the requester after accept must not affect the result
    w = '{2'b01, 4'h7, 4'h1, 2'b00, 4'h0, 4'h0, 2'b00, 1'b0, 4'h8, 1'b0};
    @(negedge clk);
    set_ops(w);
    bus.req_valid = 2'b01;
    #1;
    chk("latch accept", bus.req_ready, 2'b01);
    @(negedge clk);
    bus.req0_a    = 4'h0;
    bus.req_valid = 2'b00;
    #1;
    chk("latch exec ula_a", ula_a, 4'h7);
    @(negedge clk);
    #1;
    chk("latch resp", {bus.resp_valid, bus.resp_resul, bus.resp_flag}, {2'b01, 4'h8, 1'b0});
    bus.resp_ready = 2'b01;
    @(negedge clk);
    bus.resp_ready = 2'b00;

    // Reset during EXEC: op dropped, priority returns to ch0 (it was ch1 here)
    w = '{2'b01, 4'h1, 4'h1, 2'b00, 4'h2, 4'h2, 2'b00, 1'b0, 4'h2, 1'b0};
    @(negedge clk);
    set_ops(w);
    bus.req_valid = 2'b01;
    #1;
    chk("rst-exec accept", bus.req_ready, 2'b01);
    @(negedge clk);
    rst           = 1'b1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk("rst-exec dropped", {bus.resp_valid, busy, grant_id}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    bus.req_valid = 2'b11;
    #1;
    chk("rst-exec prio ch0", bus.req_ready, 2'b01);

    // Reset during RESP: response withdrawn the next cycle
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk("rst-resp before", bus.resp_valid, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst-resp dropped", {bus.resp_valid, busy, bus.resp_resul, bus.resp_flag}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    bus.req_valid = 2'b11;
    #1;
    chk("rst-resp prio ch0", bus.req_ready, 2'b01);
    bus.req_valid = 2'b00;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
